// File: rtl/norn_pkg.sv
// Shared phase encoding and counter width for the norn_stage adiabatic NOR block.
package norn_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL    = 3'd1,
    HOLD    = 3'd2,
    RECOVER = 3'd3,
    WAIT    = 3'd4
  } phase_t;

  localparam int EVALCNT_W = 16;

  function automatic logic [EVALCNT_W-1:0] sat_inc(input logic [EVALCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/norn_stage_pclk_seq.sv
// Four-phase power-clock sequencer: evaluate -> hold -> recover -> wait, each PHASE_CYCLES long.
module pclk_seq
  import norn_pkg::*;
#(
  parameter int PHASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       accept,
  output logic       eval_done,
  output logic       hold_done,
  output logic       out_valid,
  output logic       clkpos,
  output logic       clkneg,
  output logic [2:0] phase
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  phase_t        state;
  logic [CW-1:0] cnt;
  logic          last;

  assign last      = (cnt == LAST);
  assign in_ready  = (state == IDLE) || ((state == WAIT) && last);
  assign accept    = in_valid & in_ready;
  assign eval_done = (state == EVAL) && last;
  assign hold_done = (state == HOLD) && last;
  assign phase     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      clkpos    <= 1'b0;
      clkneg    <= 1'b1;
    end else if (accept) begin
      // Covers both a fresh start from IDLE and a back-to-back start from the last WAIT cycle.
      state     <= EVAL;
      cnt       <= '0;
      out_valid <= 1'b0;
      clkpos    <= 1'b1;
      clkneg    <= 1'b0;
    end else if (state != IDLE) begin
      if (!last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          EVAL: begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
          HOLD: begin
            state     <= RECOVER;
            out_valid <= 1'b0;
            clkpos    <= 1'b0;
            clkneg    <= 1'b1;
          end
          RECOVER: state <= WAIT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/norn_stage.sv
// Multi-lane N-input adiabatic NOR stage; NORN_EVALCNT_EN adds a saturating evaluation counter.
module norn_stage
  import norn_pkg::*;
#(
  parameter int NIN          = 3,
  parameter int LANES        = 8,
  parameter int PHASE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*NIN-1:0] a,
  output logic [LANES-1:0]     out,
  output logic                 out_valid,
  output logic                 clkpos,
  output logic                 clkneg,
  output logic [2:0]           phase
`ifdef NORN_EVALCNT_EN
  ,
  output logic [EVALCNT_W-1:0] evalcnt
`endif
);

  logic                 accept;
  logic                 hold_done;
  logic                 eval_done;
  logic [LANES*NIN-1:0] operand_reg;
  logic [LANES*NIN-1:0] operand_next;
  logic [LANES-1:0]     nor_next;

  pclk_seq #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .accept   (accept),
    .eval_done(eval_done),
    .hold_done(hold_done),
    .out_valid(out_valid),
    .clkpos   (clkpos),
    .clkneg   (clkneg),
    .phase    (phase)
  );

  assign operand_next = accept ? a : operand_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign nor_next[gi] = ~|operand_next[gi*NIN +: NIN];
    end
  endgenerate

  // Node is charged through EVAL and HOLD and returned to vss for the rest of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_reg <= '0;
      out         <= '0;
    end else begin
      operand_reg <= operand_next;
      if (accept || (clkpos && !hold_done))
        out <= nor_next;
      else
        out <= '0;
    end
  end

`ifdef NORN_EVALCNT_EN
  logic [EVALCNT_W-1:0] evalcnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      evalcnt_reg <= '0;
    else if (eval_done)
      evalcnt_reg <= sat_inc(evalcnt_reg);
  end

  assign evalcnt = evalcnt_reg;
`else
  logic unused_eval_done;
  assign unused_eval_done = eval_done;
`endif

endmodule

// File: tb/tb_norn_stage.sv
// Randomised and directed bench for norn_stage against a phase-timeline reference model.
module tb_norn_stage;

  localparam int NIN   = 3;
  localparam int LANES = 4;
  localparam int P     = 2;
  localparam int AW    = NIN * LANES;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    a;
  logic [LANES-1:0] out;
  logic             out_valid;
  logic             clkpos;
  logic             clkneg;
  logic [2:0]       phase;
`ifdef NORN_EVALCNT_EN
  logic [15:0]      evalcnt;
`endif

  norn_stage #(
    .NIN(NIN), .LANES(LANES), .PHASE_CYCLES(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out(out), .out_valid(out_valid), .clkpos(clkpos), .clkneg(clkneg), .phase(phase)
`ifdef NORN_EVALCNT_EN
    , .evalcnt(evalcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [LANES-1:0] nor_of(input logic [AW-1:0] op);
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++) r[i] = (op[i*NIN +: NIN] == 0);
    return r;
  endfunction

  // Reference: t = cycles since the accepting edge (0 = idle); phase follows from t by division.
  int            t;
  logic [AW-1:0] op;
  int            mcnt;
  bit            preload_pend = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t    <= 0;
      op   <= '0;
      mcnt <= 0;
    end else begin
      if (in_valid && (t == 0 || t == 4*P)) begin
        t  <= 1;
        op <= a;
        $display("accept a=%b expect out=%b", a, nor_of(a));
      end else if (t != 0) begin
        t <= (t == 4*P) ? 0 : t + 1;
      end
      if (preload_pend)   mcnt <= 16'hFFFE;
      else if (t == P)    mcnt <= (mcnt == 16'hFFFF) ? mcnt : mcnt + 1;
    end
  end

  always @(negedge clk) begin
    int ph;
    if (chk_en) begin
      ph = (t == 0) ? 0 : 1 + (t - 1) / P;
      chk("out", 32'(out), (ph == 1 || ph == 2) ? 32'(nor_of(op)) : 32'd0);
      chk("out_valid", 32'(out_valid), 32'(ph == 2));
      chk("clkpos", 32'(clkpos), 32'(ph == 1 || ph == 2));
      chk("clkneg", 32'(clkneg), 32'(!(ph == 1 || ph == 2)));
      chk("phase", 32'(phase), 32'(ph));
      chk("in_ready", 32'(in_ready), 32'(t == 0 || t == 4*P));
`ifdef NORN_EVALCNT_EN
      chk("evalcnt", 32'(evalcnt), 32'(mcnt));
`endif
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [AW-1:0] v);
    in_valid = 1'b1;
    a        = v;
    step();
    in_valid = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    logic [AW-1:0] opk;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    step();
    step();
    chk_en = 1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_clkneg", 32'(clkneg), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Directed single operation: lanes 000,001,111,000 -> out 1001.
    in_valid = 1'b1;
    a        = 12'b000_111_001_000;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t1_out_valid_c%0d", c), 32'(out_valid), 32'(c == 3 || c == 4));
      chk($sformatf("t1_clkpos_c%0d", c), 32'(clkpos), 32'(c >= 1 && c <= 4));
      chk($sformatf("t1_in_ready_c%0d", c), 32'(in_ready), 32'(c == 8));
      if (c == 3) chk("t1_out", 32'(out), 32'b1001);
      if (c < 8) begin
        a = AW'($urandom);
        step();
      end
    end
    step();

    // Back-to-back accepts with a scrambled between them.
    in_valid = 1'b1;
    a        = AW'($urandom);
    for (int k = 0; k < 3; k++) begin
      opk = a;
      step();
      for (int c = 1; c <= 8; c++) begin
        if (c == 3) chk($sformatf("b2b_out_%0d", k), 32'(out), 32'(nor_of(opk)));
        chk($sformatf("b2b_ready_%0d_c%0d", k, c), 32'(in_ready), 32'(c == 8));
        if (c < 8) begin
          a = AW'($urandom);
          step();
        end
      end
      a = AW'($urandom);
    end
    in_valid = 1'b0;
    step();
    step();

    // in_valid pulses while busy must not disturb the sequence.
    run_op(12'b001_000_000_010);
    in_valid = 1'b1;
    a        = '0;
    step();
    for (int c = 1; c <= 6; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      a        = AW'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("pulse_phase_wait", 32'(phase), 32'd4);
    step();
    chk("pulse_ready_end", 32'(in_ready), 32'd1);
    step();

    // Asynchronous reset in the middle of HOLD.
    in_valid = 1'b1;
    a        = '0;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rst_pre_out", 32'(out), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", 32'(out), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_clkpos", 32'(clkpos), 32'd0);
    chk("rst_mid_clkneg", 32'(clkneg), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_post_phase", 32'(phase), 32'd0);
    chk("rst_post_ready", 32'(in_ready), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      a        = AW'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();

`ifdef NORN_EVALCNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) run_op(AW'($urandom));
    chk("evalcnt_three", 32'(evalcnt), 32'd3);
    chk_en = 0;
    force dut.evalcnt_reg = 16'hFFFE;
    preload_pend = 1;
    step();
    preload_pend = 0;
    release dut.evalcnt_reg;
    chk_en = 1;
    run_op(AW'($urandom));
    run_op(AW'($urandom));
    chk("evalcnt_sat", 32'(evalcnt), 32'hFFFF);
`endif

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
